// File: rtl/mem_port_arbiter.sv
//==============================================================================
// mem_port_arbiter : shares one multi-cycle single-port memory between the
// fetch (i_*) and data (d_*) ports. Optional macro ARB_RR_EN enables round-robin.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall
);

  localparam int c_cnt_w = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAITST = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sel_d;
  logic               r_we;
  logic               r_m_en;
  logic               r_m_we;
  logic [ADDR_W-1:0]  r_m_addr;
  logic [DATA_W-1:0]  r_m_wdata;
  logic               r_i_ack;
  logic               r_d_ack;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               w_any_req;
  logic               w_grant_d;

  assign w_any_req = i_req | d_req;

`ifdef ARB_RR_EN
  logic r_last_i;
  // On contention the port that did not win last time gets the memory.
  assign w_grant_d = d_req & (~i_req | r_last_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_i <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_i <= ~w_grant_d;
    end
  end
`else
  assign w_grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel_d   <= 1'b0;
      r_we      <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          if (w_any_req) begin
            // Fetch port is read-only, so d_we only counts for a data grant.
            r_sel_d   <= w_grant_d;
            r_we      <= w_grant_d & d_we;
            r_m_en    <= 1'b1;
            r_m_we    <= w_grant_d & d_we;
            r_m_addr  <= w_grant_d ? d_addr : i_addr;
            r_m_wdata <= w_grant_d ? d_wdata : '0;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_m_en    <= 1'b0;
          r_m_we    <= 1'b0;
          r_m_addr  <= '0;
          r_m_wdata <= '0;
          r_cnt     <= c_cnt_init;
          r_state   <= S_WAITST;
        end
        S_WAITST: begin
          if (r_cnt == '0) begin
            // m_rdata is valid exactly in this last wait cycle.
            if (!r_we) begin
              if (r_sel_d) begin
                r_d_rdata <= m_rdata;
              end else begin
                r_i_rdata <= m_rdata;
              end
            end
            r_d_ack <= r_sel_d;
            r_i_ack <= ~r_sel_d;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_en    = r_m_en;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign stall   = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);

endmodule

`default_nettype wire
